// File: rtl/lenet_axil_pkg.sv
// Shared register map, bit positions and response codes for the LeNet AXI-Lite stream controller.
// Latency: none (definitions and a pure combinational decode helper).
// Backpressure: not applicable.
package lenet_axil_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_RESULT = 6'h08;
  localparam logic [5:0] ADDR_LEVEL  = 6'h0C;
  localparam logic [5:0] ADDR_CH0    = 6'h10;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_SOFT_RST_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  // Bit offset of the per-FIFO full flags inside LEVEL
  localparam int LEVEL_FULL_OFS = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_RESULT,
    SEL_LEVEL,
    SEL_CH,
    SEL_NONE
  } reg_sel_e;

  // Map a byte address to the register it selects; channel windows beyond n_ch are unmapped.
  function automatic reg_sel_e decode_addr(input logic [5:0] addr, input int n_ch);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == ADDR_CTRL) begin
      sel = SEL_CTRL;
    end else if (addr == ADDR_STATUS) begin
      sel = SEL_STATUS;
    end else if (addr == ADDR_RESULT) begin
      sel = SEL_RESULT;
    end else if (addr == ADDR_LEVEL) begin
      sel = SEL_LEVEL;
    end else if ((addr[1:0] == 2'b00) && (addr >= ADDR_CH0) &&
                 ({28'd0, addr[5:2]} < 32'(4 + n_ch))) begin
      sel = SEL_CH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/lenet_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; extra pointer bit separates full from empty.
// Latency: a pushed word is visible on rdata_o the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush beats push/pop.
module lenet_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the top bit toggles on wrap so equal indices can mean full or empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/lenet_axil_stream_ctrl.sv
// AXI4-Lite control/status block feeding N_CH write-stream FIFOs and handshaking with the LeNet core.
// Latency: B and R responses one cycle after acceptance; pushed words reach m_tdata the next cycle.
// Backpressure: one outstanding write and one read; full channel FIFOs drop data with SLVERR.
module lenet_axil_stream_ctrl
  import lenet_axil_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 32,
  parameter int RES_W      = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [5:0]             AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_W-1:0]      WDATA,
  input  logic [DATA_W/8-1:0]    WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [5:0]             ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATA_W-1:0]      RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [N_CH*DATA_W-1:0] m_tdata,
  output logic [N_CH-1:0]        m_tvalid,
  input  logic [N_CH-1:0]        m_tready,
  output logic                   core_start,
  output logic                   core_soft_rst,
  input  logic                   core_done,
  input  logic [RES_W-1:0]       core_result,
  output logic                   irq
);

  logic [1:0]        rst_sync_q;
  logic              rst_n;

  logic              wr_fire;
  logic              rd_fire;
  reg_sel_e          wr_sel;
  reg_sel_e          rd_sel;

  logic [N_CH-1:0]   ch_hit;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;
  logic [N_CH-1:0]   empty;
  logic [N_CH-1:0]   full;
  logic              ovf_hit;

  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] level_w;

  logic              ctrl_wr;
  logic              start_rise;
  logic              done_rise;
  logic              start_q, start_d;
  logic              irq_en_q, irq_en_d;
  logic              soft_q, soft_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              core_done_q;
  logic [RES_W-1:0]  result_q, result_d;

  logic              unused_wstrb;
  assign unused_wstrb = ^WSTRB;

  // Reset asserts immediately and releases two ACLK edges after ARESETN rises
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign wr_sel  = decode_addr(AWADDR, N_CH);
  assign rd_sel  = decode_addr(ARADDR, N_CH);
  assign wr_fire = rst_n && AWVALID && WVALID && !bvalid_q;
  assign rd_fire = rst_n && ARVALID && !rvalid_q;

  assign AWREADY = wr_fire;
  assign WREADY  = wr_fire;
  assign ARREADY = rd_fire;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_hit[k]   = (wr_sel == SEL_CH) && (AWADDR[5:2] == 4'(4 + k));
    assign pop[k]      = m_tready[k] && !empty[k];
    assign push[k]     = wr_fire && ch_hit[k] && (!full[k] || pop[k]);
    assign m_tvalid[k] = !empty[k];

    lenet_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
    ) u_fifo (
      .clk_i   (ACLK),
      .rst_ni  (rst_n),
      .flush_i (soft_q),
      .push_i  (push[k]),
      .wdata_i (WDATA),
      .pop_i   (pop[k]),
      .rdata_o (m_tdata[k*DATA_W +: DATA_W]),
      .empty_o (empty[k]),
      .full_o  (full[k])
    );
  end

  // A write into a full FIFO that is not draining this cycle is dropped
  assign ovf_hit = wr_fire && |(ch_hit & full & ~pop);

  // LEVEL view: empty flags in the low byte, full flags from bit 8
  always_comb begin
    level_w = '0;
    for (int k = 0; k < N_CH; k++) begin
      level_w[k]                  = empty[k];
      level_w[LEVEL_FULL_OFS + k] = full[k];
    end
  end

  // Read data selection; unmapped and write-only locations read as zero
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_CTRL: begin
        rd_mux[CTRL_START_BIT]  = start_q;
        rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      SEL_STATUS: begin
        rd_mux[STATUS_DONE_BIT] = done_q;
        rd_mux[STATUS_OVF_BIT]  = ovf_q;
      end
      SEL_RESULT: rd_mux[RES_W-1:0] = result_q;
      SEL_LEVEL:  rd_mux = level_w;
      default:    rd_mux = '0;
    endcase
  end

  // AXI response channels: capture on acceptance, hold until the master takes it
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = ((wr_sel == SEL_NONE) || ovf_hit) ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
      rresp_d  = (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Control and status updates; soft reset clears last so it wins over same-cycle events
  always_comb begin
    ctrl_wr    = wr_fire && (wr_sel == SEL_CTRL);
    start_d    = ctrl_wr ? WDATA[CTRL_START_BIT]  : start_q;
    irq_en_d   = ctrl_wr ? WDATA[CTRL_IRQ_EN_BIT] : irq_en_q;
    soft_d     = ctrl_wr && WDATA[CTRL_SOFT_RST_BIT];
    start_rise = ctrl_wr && WDATA[CTRL_START_BIT] && !start_q;
    done_rise  = core_done && !core_done_q;

    done_d   = done_q;
    result_d = result_q;
    ovf_d    = ovf_q || ovf_hit;
    if (start_rise) done_d = 1'b0;
    if (done_rise) begin
      done_d   = 1'b1;
      result_d = core_result;
    end
    if (soft_q) begin
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      result_d = '0;
    end
    irq_d = done_d && irq_en_d;
  end

  // State registers for the AXI responses and control/status
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      start_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      soft_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      core_done_q <= 1'b0;
      result_q    <= '0;
    end else begin
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      start_q     <= start_d;
      irq_en_q    <= irq_en_d;
      soft_q      <= soft_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      core_done_q <= core_done;
      result_q    <= result_d;
    end
  end

  assign core_start    = start_q;
  assign core_soft_rst = soft_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_lenet_axil_stream_ctrl.sv
// Randomized bench for lenet_axil_stream_ctrl against a queue-based register/stream model.
// Latency: checks are made at falling edges, after the DUT has settled.
// Backpressure: stream pops are scored by a posedge monitor whenever m_tready is driven high.
module tb_lenet_axil_stream_ctrl;

  localparam int N_CH  = 3;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [5:0]        AWADDR;
  logic              AWVALID, AWREADY;
  logic [DW-1:0]     WDATA;
  logic [DW/8-1:0]   WSTRB;
  logic              WVALID, WREADY;
  logic [1:0]        BRESP;
  logic              BVALID, BREADY;
  logic [5:0]        ARADDR;
  logic              ARVALID, ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID, RREADY;
  logic [N_CH*DW-1:0] m_tdata;
  logic [N_CH-1:0]   m_tvalid, m_tready;
  logic              core_start, core_soft_rst, core_done, irq;
  logic [RW-1:0]     core_result;

  int n_checks = 0;
  int n_errors = 0;
  int soft_cnt = 0;
  int soft_exp = 0;

  // Reference model state
  logic [DW-1:0] mq [N_CH][$];
  logic          m_start, m_irqen, m_done, m_ovf;
  logic [RW-1:0] m_result;

  always #5 ACLK = ~ACLK;

  lenet_axil_stream_ctrl #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH), .DATA_W(DW), .RES_W(RW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .core_start(core_start), .core_soft_rst(core_soft_rst),
    .core_done(core_done), .core_result(core_result), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) mq[k].delete();
    m_start = 0; m_irqen = 0; m_done = 0; m_ovf = 0; m_result = '0;
  endtask

  // Register-map semantics for one accepted write
  task automatic model_write(input logic [5:0] a, input logic [DW-1:0] d, output logic [1:0] r);
    int k;
    r = OKAY;
    if (a == 6'h00) begin
      if (d[0] && !m_start) m_done = 0;
      m_start = d[0];
      m_irqen = d[2];
      if (d[1]) begin
        soft_exp++;
        for (int j = 0; j < N_CH; j++) mq[j].delete();
        m_done = 0; m_ovf = 0; m_result = '0;
      end
    end else if (a == 6'h04 || a == 6'h08 || a == 6'h0C) begin
      r = OKAY;
    end else if (a[1:0] == 2'b00 && a >= 6'h10 && int'(a) < 16 + 4 * N_CH) begin
      k = (int'(a) - 16) / 4;
      if (mq[k].size() == DEPTH) begin
        r = SLVERR;
        m_ovf = 1;
      end else begin
        mq[k].push_back(d);
      end
    end else begin
      r = SLVERR;
    end
  endtask

  task automatic model_read(input logic [5:0] a, output logic [DW-1:0] d, output logic [1:0] r);
    d = '0;
    r = OKAY;
    case (a)
      6'h00: d = {29'd0, m_irqen, 1'b0, m_start};
      6'h04: d = {30'd0, m_ovf, m_done};
      6'h08: d = {28'd0, m_result};
      6'h0C: for (int k = 0; k < N_CH; k++) begin
               d[k]     = (mq[k].size() == 0);
               d[8 + k] = (mq[k].size() == DEPTH);
             end
      default: if (!(a[1:0] == 2'b00 && a >= 6'h10 && int'(a) < 16 + 4 * N_CH)) r = SLVERR;
    endcase
  endtask

  // Stream monitor: every cycle a lane is ready with data queued, the head must come out
  always @(posedge ACLK) begin
    for (int k = 0; k < N_CH; k++) begin
      if (m_tready[k] && mq[k].size() > 0) begin
        check_eq("pop_valid", m_tvalid[k], 1'b1);
        check_eq("pop_data", m_tdata[k*DW +: DW], mq[k][0]);
        void'(mq[k].pop_front());
      end
    end
  end

  always @(posedge ACLK) if (core_soft_rst) soft_cnt++;

  task automatic chk_outs(input string tag);
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (mq[k].size() != 0);
    check_eq({tag, "_tvalid"}, m_tvalid, v);
    check_eq({tag, "_start"}, core_start, m_start);
    check_eq({tag, "_irq"}, irq, m_done && m_irqen);
    check_eq({tag, "_softcnt"}, soft_cnt, soft_exp);
    for (int k = 0; k < N_CH; k++)
      if (v[k]) check_eq({tag, "_head"}, m_tdata[k*DW +: DW], mq[k][0]);
  endtask

  task automatic axi_wr(input logic [5:0] addr, input logic [DW-1:0] data, input logic [N_CH-1:0] pop_mask);
    logic [1:0] exp_r;
    int n;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = 4'($urandom); AWVALID = 1; WVALID = 1;
    #1;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    check_eq("aw_ready", {AWREADY, WREADY}, 2'b11);
    m_tready = pop_mask;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; m_tready = '0;
    model_write(addr, data, exp_r);
    check_eq("b_valid", BVALID, 1'b1);
    check_eq("b_resp", BRESP, exp_r);
    n = $urandom_range(0, 2);
    repeat (n) @(negedge ACLK);
    if (n > 0) check_eq("b_hold", BVALID, 1'b1);
    @(negedge ACLK); BREADY = 1;
    @(posedge ACLK); #1; BREADY = 0;
    check_eq("b_clear", BVALID, 1'b0);
  endtask

  task automatic axi_rd(input logic [5:0] addr);
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    check_eq("ar_ready", ARREADY, 1'b1);
    model_read(addr, exp_d, exp_r);
    @(posedge ACLK); #1;
    ARVALID = 0;
    check_eq("r_valid", RVALID, 1'b1);
    check_eq("r_resp", RRESP, exp_r);
    check_eq("r_data", RDATA, exp_d);
    @(negedge ACLK); RREADY = 1;
    @(posedge ACLK); #1; RREADY = 0;
    check_eq("r_clear", RVALID, 1'b0);
  endtask

  task automatic pulse_done(input logic [RW-1:0] res);
    @(negedge ACLK); core_done = 1; core_result = res;
    @(negedge ACLK); core_done = 0;
    m_done = 1; m_result = res;
    check_eq("done_irq", irq, m_irqen);
  endtask

  task automatic drain(input int cycles, input logic [N_CH-1:0] mask, input bit rnd);
    repeat (cycles) begin
      @(negedge ACLK);
      m_tready = rnd ? N_CH'($urandom) : mask;
    end
    @(negedge ACLK); m_tready = '0;
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog elapsed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] a;
    int op;
    ARESETN = 0; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0; m_tready = 0; core_done = 0; core_result = 0;
    model_reset();
    repeat (3) @(negedge ACLK);
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    #1;
    check_eq("rst_awready", AWREADY, 1'b0);
    check_eq("rst_arready", ARREADY, 1'b0);
    check_eq("rst_bvalid", BVALID, 1'b0);
    check_eq("rst_rvalid", RVALID, 1'b0);
    check_eq("rst_softrst", core_soft_rst, 1'b0);
    chk_outs("rst");
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK); ARESETN = 1;
    repeat (4) @(negedge ACLK);
    chk_outs("post_rst");
    axi_rd(6'h04);
    axi_rd(6'h0C);

    // Single word into channel 0 stays visible while not ready
    axi_wr(6'h10, 32'hAB, '0);
    check_eq("ch0_data", m_tdata[31:0], 32'hAB);
    chk_outs("ch0");
    axi_rd(6'h0C);
    drain(2, 3'b001, 0);

    // Overfill channel 1, then confirm order on the way out
    for (int i = 0; i < DEPTH + 1; i++) axi_wr(6'h14, 32'h100 + i, '0);
    axi_rd(6'h04);
    axi_rd(6'h0C);
    drain(DEPTH + 2, 3'b010, 0);
    chk_outs("ovf_drain");

    // Unmapped accesses
    axi_rd(6'h30);
    axi_wr(6'h2C, 32'hDEAD, '0);
    chk_outs("unmapped");
    axi_rd(6'h0C);

    // Start / done / irq sequence
    axi_wr(6'h00, 32'h5, '0);
    chk_outs("start");
    pulse_done(4'd7);
    axi_rd(6'h04);
    axi_rd(6'h08);
    axi_wr(6'h00, 32'h4, '0);
    chk_outs("ctrl4");
    axi_wr(6'h00, 32'h5, '0);
    chk_outs("ctrl5");
    axi_rd(6'h04);

    // Soft reset with data pending in channel 2 and sticky flags set
    pulse_done(4'd3);
    for (int i = 0; i < 5; i++) axi_wr(6'h18, 32'h200 + i, '0);
    axi_wr(6'h00, 32'h2, '0);
    chk_outs("soft");
    axi_rd(6'h04);
    axi_rd(6'h08);
    axi_rd(6'h0C);

    // Push into a full FIFO during the cycle its head is popped
    for (int i = 0; i < DEPTH; i++) axi_wr(6'h10, 32'h300 + i, '0);
    axi_wr(6'h10, 32'h3FF, 3'b001);
    axi_rd(6'h0C);
    axi_rd(6'h04);
    drain(DEPTH + 2, 3'b001, 0);
    chk_outs("pushpop");

    // Randomized mix of operations
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 10);
      if (op <= 5) begin
        a = 6'(16 + 4 * $urandom_range(0, N_CH - 1));
        axi_wr(a, $urandom, '0);
      end else if (op == 6) begin
        a = 6'(28 + 4 * $urandom_range(0, 8));
        axi_wr(a, $urandom, '0);
      end else if (op == 7) begin
        axi_wr(6'h00, {29'd0, 3'($urandom_range(0, 7)) & (($urandom_range(0, 3) == 0) ? 3'b111 : 3'b101)}, '0);
      end else if (op == 8) begin
        a = ($urandom_range(0, 1) == 0) ? 6'(4 * $urandom_range(0, 3)) : 6'(28 + 4 * $urandom_range(0, 8));
        axi_rd(a);
      end else if (op == 9) begin
        pulse_done(RW'($urandom));
      end else begin
        drain($urandom_range(1, 12), '0, 1);
      end
      chk_outs("rnd");
    end
    drain(DEPTH + 4, '1, 0);
    chk_outs("final_drain");

    // Reset asserted while a write response is pending
    @(negedge ACLK);
    AWADDR = 6'h10; WDATA = 32'h1234; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check_eq("pre_rst_bvalid", BVALID, 1'b1);
    ARESETN = 0; AWVALID = 1; WVALID = 1; ARVALID = 1;
    #1;
    check_eq("mid_rst_bvalid", BVALID, 1'b0);
    check_eq("mid_rst_awready", AWREADY, 1'b0);
    check_eq("mid_rst_arready", ARREADY, 1'b0);
    model_reset();
    chk_outs("mid_rst");
    @(negedge ACLK); ARESETN = 1; AWVALID = 0; WVALID = 0; ARVALID = 0;
    repeat (3) @(negedge ACLK);
    axi_wr(6'h10, 32'hCAFE, '0);
    chk_outs("after_rst");
    axi_rd(6'h0C);
    drain(3, '1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
